// File: rtl/ssp_link_pkg.sv
// Shared types and constants for the SSP link controller.
package ssp_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ssp_state_t;

    typedef enum logic {
        SRC_DEMOD = 1'b0,
        SRC_REPLY = 1'b1
    } ssp_src_t;

    localparam logic [7:0] SSP_FILLER = 8'h00;

endpackage

// File: rtl/ssp_link_ctrl_clk_div.sv
// SSP clock divider: toggles ssp_clk every CLK_DIV enabled cycles and flags
// the cycle in which each rising/falling toggle is about to happen.
module ssp_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic en,
    input  logic clr,
    output logic ssp_clk,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tc;

    assign tc   = en && (cnt == CW'(CLK_DIV - 1));
    assign rise = tc && !ssp_clk;
    assign fall = tc && ssp_clk;

    always_ff @(posedge clk) begin
        if (!nreset || clr) begin
            cnt     <= '0;
            ssp_clk <= 1'b0;
        end else if (en) begin
            if (tc) begin
                cnt     <= '0;
                ssp_clk <= ~ssp_clk;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ssp_link_ctrl.sv
// SSP link controller: round-robin arbitration of demod/reply bytes, full-duplex
// word shifting and rx strobe. Define SSP_LOOPBACK_EN to receive the tx stream.
module ssp_link_ctrl
    import ssp_link_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = 8,
    parameter int GAP_LEN = 8
) (
    input  logic              ck_1356meg,
    input  logic              nreset,
    input  logic              poll_en,
    input  logic              demod_valid,
    input  logic [WORD_W-1:0] demod_data,
    output logic              demod_ready,
    input  logic              reply_valid,
    input  logic [WORD_W-1:0] reply_data,
    output logic              reply_ready,
    output logic              rx_valid,
    output logic [WORD_W-1:0] rx_data,
    output logic              busy,
    output logic              ssp_clk,
    output logic              ssp_frame,
    output logic              ssp_din,
    input  logic              ssp_dout
);

    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    ssp_state_t        state, state_nxt;
    ssp_src_t          last_src;
    logic [WORD_W-1:0] tx_sr, rx_sr, load_word;
    logic [BW-1:0]     bit_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              clk_rise, clk_fall, div_en, div_clr;
    logic              grant_reply, grant_demod, load, last_bit, rx_bit;

`ifdef SSP_LOOPBACK_EN
    assign rx_bit = ssp_din;
`else
    assign rx_bit = ssp_dout;
`endif

    assign busy    = (state != IDLE);
    assign div_en  = (state == SHIFT);
    assign div_clr = (state != SHIFT);

    ssp_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (ck_1356meg),
        .nreset  (nreset),
        .en      (div_en),
        .clr     (div_clr),
        .ssp_clk (ssp_clk),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    // On a tie the source that did not win last time gets the link.
    assign grant_reply = reply_valid && (!demod_valid || last_src == SRC_DEMOD);
    assign grant_demod = demod_valid && !grant_reply;
    assign last_bit    = (bit_cnt == BW'(WORD_W - 1));

    always_ff @(posedge ck_1356meg) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        demod_ready = 1'b0;
        reply_ready = 1'b0;
        load        = 1'b0;
        load_word   = WORD_W'(SSP_FILLER);
        case (state)
            IDLE: if (nreset) begin
                if (grant_reply) begin
                    reply_ready = 1'b1;
                    load        = 1'b1;
                    load_word   = reply_data;
                    state_nxt   = SHIFT;
                end else if (grant_demod) begin
                    demod_ready = 1'b1;
                    load        = 1'b1;
                    load_word   = demod_data;
                    state_nxt   = SHIFT;
                end else if (poll_en) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: if (clk_fall && last_bit) state_nxt = GAP;
            GAP:   if (gap_cnt == GW'(GAP_LEN - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ck_1356meg) begin
        if (!nreset) begin
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            ssp_frame <= 1'b0;
            ssp_din   <= 1'b0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            last_src  <= SRC_DEMOD;
        end else begin
            rx_valid <= 1'b0;
            if (load) begin
                tx_sr     <= load_word << 1;
                ssp_din   <= load_word[WORD_W-1];
                ssp_frame <= 1'b1;
                bit_cnt   <= '0;
                rx_sr     <= '0;
                if (reply_ready)      last_src <= SRC_REPLY;
                else if (demod_ready) last_src <= SRC_DEMOD;
            end
            if (state == SHIFT) begin
                // Frame covers only the first low half-period of the word.
                if (clk_rise) begin
                    rx_sr     <= (rx_sr << 1) | WORD_W'(rx_bit);
                    ssp_frame <= 1'b0;
                end
                if (clk_fall) begin
                    if (last_bit) begin
                        ssp_din  <= 1'b0;
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                        gap_cnt  <= '0;
                    end else begin
                        ssp_din <= tx_sr[WORD_W-1];
                        tx_sr   <= tx_sr << 1;
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
            end
            if (state == GAP) gap_cnt <= gap_cnt + GW'(1);
        end
    end

endmodule

// File: tb/tb_ssp_link_ctrl.sv
// Bench for ssp_link_ctrl: cycle-level reference of the link timeline plus
// scoreboards for serial tx words and received rx words.
module tb_ssp_link_ctrl;

    localparam int CLK_DIV  = 4;
    localparam int WORD_W   = 8;
    localparam int GAP_LEN  = 8;
    localparam int WORD_CYC = 2 * CLK_DIV * WORD_W;
    localparam int XFER     = WORD_CYC + GAP_LEN;

    logic              clk = 1'b0, nreset = 1'b0, poll_en = 1'b0, ssp_dout = 1'b0;
    logic              demod_valid = 1'b0, reply_valid = 1'b0;
    logic [WORD_W-1:0] demod_data = '0, reply_data = '0;
    logic              demod_ready, reply_ready, rx_valid, busy;
    logic              ssp_clk, ssp_frame, ssp_din;
    logic [WORD_W-1:0] rx_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ssp_link_ctrl #(.CLK_DIV(CLK_DIV), .WORD_W(WORD_W), .GAP_LEN(GAP_LEN)) dut (
        .ck_1356meg (clk),
        .nreset     (nreset),
        .poll_en    (poll_en),
        .demod_valid(demod_valid),
        .demod_data (demod_data),
        .demod_ready(demod_ready),
        .reply_valid(reply_valid),
        .reply_data (reply_data),
        .reply_ready(reply_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .busy       (busy),
        .ssp_clk    (ssp_clk),
        .ssp_frame  (ssp_frame),
        .ssp_din    (ssp_din),
        .ssp_dout   (ssp_dout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none at %0t", name, $time);
    endtask

    // Scoreboards filled when a word is launched.
    logic [WORD_W-1:0] txq[$], rxq[$], armq[$];
    int                busy_left = 0;
    bit                last_reply = 1'b0, rst_seen = 1'b0;
    bit                dem_hs = 1'b0, rep_hs = 1'b0;
    bit                arm_fixed = 1'b0;
    logic [WORD_W-1:0] arm_pat = '0, cur_word = '0;

    // Reference timeline: a launch at cycle t0 occupies t0+1 .. t0+XFER.
    always @(negedge clk) begin : model
        int k;
        bit gr, gd, gf;
        logic [WORD_W-1:0] pat;
        dem_hs = demod_valid && demod_ready;
        rep_hs = reply_valid && reply_ready;
        if (!nreset) begin
            chk("rst_demod_ready", demod_ready, 0);
            chk("rst_reply_ready", reply_ready, 0);
            if (rst_seen) begin
                chk("rst_busy", busy, 0);
                chk("rst_ssp_clk", ssp_clk, 0);
                chk("rst_ssp_frame", ssp_frame, 0);
                chk("rst_ssp_din", ssp_din, 0);
                chk("rst_rx_valid", rx_valid, 0);
                chk("rst_rx_data", rx_data, 0);
            end
            rst_seen   = 1'b1;
            busy_left  = 0;
            last_reply = 1'b0;
            txq.delete();
            rxq.delete();
            armq.delete();
        end else begin
            rst_seen = 1'b0;
            if (busy_left > 0) begin
                k = XFER - busy_left + 1;
                chk("busy", busy, 1);
                chk("ready_while_busy", {demod_ready, reply_ready}, 0);
                if (k <= WORD_CYC) begin
                    chk("ssp_clk", ssp_clk, ((k - 1) / CLK_DIV) % 2);
                    chk("ssp_frame", ssp_frame, (k <= CLK_DIV) ? 1 : 0);
                    chk("ssp_din", ssp_din, cur_word[WORD_W - 1 - (k - 1) / (2 * CLK_DIV)]);
                    chk("rx_valid_shift", rx_valid, 0);
                end else begin
                    chk("gap_ssp_clk", ssp_clk, 0);
                    chk("gap_ssp_frame", ssp_frame, 0);
                    chk("gap_ssp_din", ssp_din, 0);
                    chk("rx_valid_gap", rx_valid, (k == WORD_CYC + 1) ? 1 : 0);
                end
                busy_left--;
            end else begin
                gr = reply_valid && (!demod_valid || !last_reply);
                gd = demod_valid && !gr;
                gf = !reply_valid && !demod_valid && poll_en;
                chk("idle_busy", busy, 0);
                chk("idle_lines", {ssp_clk, ssp_frame, ssp_din, rx_valid}, 0);
                chk("demod_ready", demod_ready, gd);
                chk("reply_ready", reply_ready, gr);
                if (gr || gd || gf) begin
                    cur_word = gr ? reply_data : (gd ? demod_data : '0);
                    if (gr)      last_reply = 1'b1;
                    else if (gd) last_reply = 1'b0;
                    pat = arm_fixed ? arm_pat : WORD_W'($urandom);
                    txq.push_back(cur_word);
                    armq.push_back(pat);
`ifdef SSP_LOOPBACK_EN
                    rxq.push_back(cur_word);
`else
                    rxq.push_back(pat);
`endif
                    busy_left = XFER;
                end
            end
        end
    end

    // Monitor: deserialise ssp_din on ssp_clk rises, and check rx strobes.
    always @(negedge clk) begin : mon
        int nb;
        bit prev_clk;
        logic [WORD_W-1:0] sh;
        if (!nreset) begin
            nb       = 0;
            prev_clk = 1'b0;
        end else begin
            if (ssp_clk && !prev_clk) begin
                sh = {sh[WORD_W-2:0], ssp_din};
                nb++;
                if (nb == WORD_W) begin
                    nb = 0;
                    if (txq.size() == 0) fail_now("tx_word_unexpected");
                    else chk("tx_word", sh, txq.pop_front());
                end
            end
            prev_clk = ssp_clk;
            if (rx_valid) begin
                if (rxq.size() == 0) fail_now("rx_valid_unexpected");
                else chk("rx_data", rx_data, rxq.pop_front());
            end
        end
    end

    // ARM side: presents each pattern bit, changing it after ssp_clk rises.
    always @(posedge clk) begin : arm
        int idx;
        bit pf, pc, b;
        logic [WORD_W-1:0] cur;
        #2;
        b = 1'b0;
        if (!nreset) begin
            pf = 1'b0; pc = 1'b0; idx = WORD_W;
        end else begin
            if (ssp_frame && !pf) begin
                cur = (armq.size() > 0) ? armq.pop_front() : '0;
                idx = 0;
            end else if (ssp_clk && !pc) begin
                idx++;
            end
            if (idx < WORD_W) b = cur[WORD_W - 1 - idx];
            pf = ssp_frame;
            pc = ssp_clk;
        end
`ifdef SSP_LOOPBACK_EN
        ssp_dout = 1'b0;
`else
        ssp_dout = b;
`endif
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input bit rep);
        for (int n = 0; n < 4 * XFER; n++) begin
            @(negedge clk);
            if (rep ? (reply_valid && reply_ready) : (demod_valid && demod_ready)) begin
                cycles(1);
                return;
            end
        end
        fail_now("handshake_timeout");
        cycles(1);
    endtask

    initial begin
        cycles(3);
        nreset = 1'b1;

        // Single demod byte 0xA5.
        demod_data = 8'hA5; demod_valid = 1'b1;
        wait_hs(1'b0);
        demod_valid = 1'b0;
        cycles(XFER + 10);

        // Both sources valid continuously: expect alternation, reply first.
        demod_data = 8'h11; reply_data = 8'h22;
        demod_valid = 1'b1; reply_valid = 1'b1;
        cycles(5 * (XFER + 1));
        demod_valid = 1'b0; reply_valid = 1'b0;
        cycles(XFER + 5);

        // Poll filler while the ARM sends 0x3C.
        arm_fixed = 1'b1; arm_pat = 8'h3C; poll_en = 1'b1;
        cycles(5);
        poll_en = 1'b0;
        cycles(XFER + 5);
        arm_fixed = 1'b0;

        // Reset in cycle 30 of a reply word with both sources pending.
        reply_data = 8'h96; reply_valid = 1'b1;
        wait_hs(1'b1);
        demod_data = 8'h5A; demod_valid = 1'b1;
        cycles(29);
        nreset = 1'b0;
        cycles(2);
        nreset = 1'b1;
        cycles(3 * (XFER + 1));
        demod_valid = 1'b0; reply_valid = 1'b0;
        cycles(XFER + 5);

        // Randomised traffic, including drops of valid without handshake.
        for (int c = 0; c < 3000; c++) begin
            if (!demod_valid || dem_hs) begin
                demod_valid = ($urandom_range(0, 2) == 0);
                demod_data  = WORD_W'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                demod_valid = 1'b0;
            end
            if (!reply_valid || rep_hs) begin
                reply_valid = ($urandom_range(0, 2) == 0);
                reply_data  = WORD_W'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                reply_valid = 1'b0;
            end
            if ($urandom_range(0, 99) == 0) poll_en = ~poll_en;
            cycles(1);
        end
        demod_valid = 1'b0; reply_valid = 1'b0; poll_en = 1'b0;
        cycles(XFER + 5);

        chk("txq_drained", txq.size(), 0);
        chk("rxq_drained", rxq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
